// File: rtl/issue_scoreboard_if.sv
// Decoder, issue, writeback and status signals of the issue scoreboard.
// The slave modport is the scoreboard; the master modport is its environment.
interface issue_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic             i_dec_valid;
  logic             o_dec_ready;
  logic [4:0]       i_dec_rs1;
  logic [4:0]       i_dec_rs2;
  logic [4:0]       i_dec_rd;
  logic             i_dec_rs1_en;
  logic             i_dec_rs2_en;
  logic             i_dec_rd_en;
  logic [XLEN-1:0]  i_dec_imm;
  logic [XLEN-1:0]  i_dec_pc;

  logic             o_issue_valid;
  logic             i_issue_ready;
  logic [4:0]       o_issue_rs1;
  logic [4:0]       o_issue_rs2;
  logic [4:0]       o_issue_rd;
  logic [XLEN-1:0]  o_issue_imm;
  logic [XLEN-1:0]  o_issue_pc;

  logic             i_wb_valid;
  logic [4:0]       i_wb_rd;
  logic             i_flush;

  logic [31:0]      o_busy;
  logic [CNT_W-1:0] o_stall_count;

  modport slave (
    input  i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd,
           i_dec_rs1_en, i_dec_rs2_en, i_dec_rd_en, i_dec_imm, i_dec_pc,
           i_issue_ready, i_wb_valid, i_wb_rd, i_flush,
    output o_dec_ready, o_issue_valid, o_issue_rs1, o_issue_rs2, o_issue_rd,
           o_issue_imm, o_issue_pc, o_busy, o_stall_count
  );

  modport master (
    output i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd,
           i_dec_rs1_en, i_dec_rs2_en, i_dec_rd_en, i_dec_imm, i_dec_pc,
           i_issue_ready, i_wb_valid, i_wb_rd, i_flush,
    input  o_dec_ready, o_issue_valid, o_issue_rs1, o_issue_rs2, o_issue_rd,
           o_issue_imm, o_issue_pc, o_busy, o_stall_count
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one decoded instruction, stalls on RAW/WAW
// hazards against a per-register pending-write scoreboard, then offers it to execute.
module issue_scoreboard #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  issue_scoreboard_if.slave  sb
);

  typedef enum logic [1:0] {IDLE, HAZARD, ISSUE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [31:0]      wb_clr;
  logic [31:0]      eff_busy;
  logic             hazard;
  logic             dec_ready;
  logic             issue_valid;
  logic             accept;
  logic             issue_fire;

  // Disabled operands are stored as x0, so a non-zero held index implies its enable.
  always_comb begin
    wb_clr = '0;
    if (sb.i_wb_valid) wb_clr[sb.i_wb_rd] = 1'b1;
    eff_busy = busy_q & ~wb_clr;
    hazard   = ((rs1_q != 5'd0) && eff_busy[rs1_q]) ||
               ((rs2_q != 5'd0) && eff_busy[rs2_q]) ||
               ((rd_q  != 5'd0) && eff_busy[rd_q]);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = HAZARD;
      HAZARD:  if (sb.i_flush) state_d = IDLE;
               else if (!hazard) state_d = ISSUE;
      ISSUE:   if (sb.i_flush || sb.i_issue_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dec_ready   = (state_q == IDLE);
    issue_valid = (state_q == ISSUE) && !sb.i_flush && !i_reset;
    accept      = dec_ready && sb.i_dec_valid && !sb.i_flush;
    issue_fire  = issue_valid && sb.i_issue_ready;
  end

  always_comb begin
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    stall_d = stall_q;
    if (accept) begin
      rs1_d = sb.i_dec_rs1_en ? sb.i_dec_rs1 : 5'd0;
      rs2_d = sb.i_dec_rs2_en ? sb.i_dec_rs2 : 5'd0;
      rd_d  = sb.i_dec_rd_en  ? sb.i_dec_rd  : 5'd0;
      imm_d = sb.i_dec_imm;
      pc_d  = sb.i_dec_pc;
    end
    if ((state_q == HAZARD) && hazard && !sb.i_flush && (stall_q != '1))
      stall_d = stall_q + 1'b1;
    // Clear before set so an issuing destination wins over a same-index writeback.
    busy_d = busy_q & ~wb_clr;
    if (issue_fire && (rd_q != 5'd0)) busy_d[rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign sb.o_dec_ready   = dec_ready;
  assign sb.o_issue_valid = issue_valid;
  assign sb.o_issue_rs1   = rs1_q;
  assign sb.o_issue_rs2   = rs2_q;
  assign sb.o_issue_rd    = rd_q;
  assign sb.o_issue_imm   = imm_q;
  assign sb.o_issue_pc    = pc_q;
  assign sb.o_busy        = busy_q;
  assign sb.o_stall_count = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: expected issue packets are queued at
// decoder accept and compared when the execute handshake fires.
module tb_issue_scoreboard;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } pkt_t;

  logic i_clk;
  logic i_reset;
  int   n_checks;
  int   n_pass;
  pkt_t exp_q[$];

  issue_scoreboard_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  issue_scoreboard #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .sb      (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  // Scoreboard side: every execute handshake must match the oldest queued packet.
  always @(negedge i_clk) begin
    if (!i_reset && bus.o_issue_valid && bus.i_issue_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_issue", 64'd1, 64'd0);
      end else begin
        pkt_t p;
        p = exp_q.pop_front();
        check_eq("issue_rs1", 64'(bus.o_issue_rs1), 64'(p.rs1));
        check_eq("issue_rs2", 64'(bus.o_issue_rs2), 64'(p.rs2));
        check_eq("issue_rd",  64'(bus.o_issue_rd),  64'(p.rd));
        check_eq("issue_imm", 64'(bus.o_issue_imm), 64'(p.imm));
        check_eq("issue_pc",  64'(bus.o_issue_pc),  64'(p.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered at posedge+1; leaves at posedge+1 of the cycle after the accept edge.
  task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic e1, input logic e2, input logic ed,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
    pkt_t p;
    bus.i_dec_valid  = 1'b1;
    bus.i_dec_rs1    = rs1;
    bus.i_dec_rs2    = rs2;
    bus.i_dec_rd     = rd;
    bus.i_dec_rs1_en = e1;
    bus.i_dec_rs2_en = e2;
    bus.i_dec_rd_en  = ed;
    bus.i_dec_imm    = imm;
    bus.i_dec_pc     = pc;
    mid();
    check_eq("dec_ready_at_accept", 64'(bus.o_dec_ready), 64'd1);
    p.rs1 = e1 ? rs1 : 5'd0;
    p.rs2 = e2 ? rs2 : 5'd0;
    p.rd  = ed ? rd  : 5'd0;
    p.imm = imm;
    p.pc  = pc;
    exp_q.push_back(p);
    cyc();
    bus.i_dec_valid = 1'b0;
  endtask

  // Hazard-free destination-only instruction, returns at posedge+1 of the next IDLE cycle.
  task automatic run_simple(input logic [4:0] rd, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
    bus.i_issue_ready = 1'b1;
    accept(5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1, imm, pc);
    cyc();
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.i_dec_valid  = 1'b0;
    bus.i_dec_rs1    = '0;
    bus.i_dec_rs2    = '0;
    bus.i_dec_rd     = '0;
    bus.i_dec_rs1_en = 1'b0;
    bus.i_dec_rs2_en = 1'b0;
    bus.i_dec_rd_en  = 1'b0;
    bus.i_dec_imm    = '0;
    bus.i_dec_pc     = '0;
    bus.i_issue_ready = 1'b0;
    bus.i_wb_valid   = 1'b0;
    bus.i_wb_rd      = '0;
    bus.i_flush      = 1'b0;

    // Reset state
    i_reset = 1'b1;
    cyc(); cyc();
    i_reset = 1'b0;
    mid();
    check_eq("rst_busy",  64'(bus.o_busy), 64'd0);
    check_eq("rst_stall", 64'(bus.o_stall_count), 64'd0);
    check_eq("rst_valid", 64'(bus.o_issue_valid), 64'd0);
    check_eq("rst_ready", 64'(bus.o_dec_ready), 64'd1);
    check_eq("rst_rd",    64'(bus.o_issue_rd), 64'd0);
    check_eq("rst_pc",    64'(bus.o_issue_pc), 64'd0);
    cyc();

    // No hazard: minimum latency
    bus.i_issue_ready = 1'b1;
    accept(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0100);
    mid();
    check_eq("lat_n1_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc(); mid();
    check_eq("lat_n2_valid", 64'(bus.o_issue_valid), 64'd1);
    cyc(); mid();
    check_eq("lat_n3_busy",  64'(bus.o_busy), 64'h20);
    check_eq("lat_n3_ready", 64'(bus.o_dec_ready), 64'd1);
    cyc();

    // RAW on x5: four stalled cycles, then bypassed writeback
    bus.i_issue_ready = 1'b0;
    accept(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0104);
    for (int unsigned i = 0; i < 4; i++) begin
      mid();
      check_eq("raw_stall_valid", 64'(bus.o_issue_valid), 64'd0);
      cyc();
    end
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = 5'd5;
    mid();
    check_eq("raw_wb_cycle_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc();
    bus.i_wb_valid    = 1'b0;
    bus.i_issue_ready = 1'b1;
    mid();
    check_eq("raw_issue_valid", 64'(bus.o_issue_valid), 64'd1);
    check_eq("raw_stall_count", 64'(bus.o_stall_count), 64'd4);
    check_eq("raw_busy_clear",  64'(bus.o_busy), 64'd0);
    cyc();
    bus.i_issue_ready = 1'b0;
    mid();
    check_eq("raw_busy_set", 64'(bus.o_busy), 64'h40);
    cyc();

    // Bypass on rs2=x7 in the same cycle as the hazard evaluation
    run_simple(5'd7, 32'h7, 32'h0000_0108);
    mid();
    check_eq("byp_busy_pre", 64'(bus.o_busy), 64'hC0);
    cyc();
    bus.i_issue_ready = 1'b0;
    accept(5'd0, 5'd7, 5'd8, 1'b0, 1'b1, 1'b1, 32'h0000_0808, 32'h0000_010C);
    mid();
    check_eq("byp_hazard_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = 5'd7;
    mid();
    check_eq("byp_wb_cycle_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc();
    bus.i_wb_valid = 1'b0;
    mid();
    check_eq("byp_issue_valid", 64'(bus.o_issue_valid), 64'd1);
    check_eq("byp_busy7_clear", 64'(bus.o_busy), 64'h40);
    check_eq("byp_stall_count", 64'(bus.o_stall_count), 64'd5);
    bus.i_issue_ready = 1'b1;
    cyc();
    bus.i_issue_ready = 1'b0;
    mid();
    check_eq("byp_busy_after", 64'(bus.o_busy), 64'h140);
    cyc();

    // Set wins over a same-cycle writeback on the issuing destination
    accept(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0110);
    cyc();
    bus.i_issue_ready = 1'b1;
    bus.i_wb_valid    = 1'b1;
    bus.i_wb_rd       = 5'd3;
    mid();
    check_eq("setwin_valid", 64'(bus.o_issue_valid), 64'd1);
    cyc();
    bus.i_issue_ready = 1'b0;
    bus.i_wb_valid    = 1'b0;
    mid();
    check_eq("setwin_busy", 64'(bus.o_busy), 64'h148);
    cyc();

    // Writebacks drain everything; x0 writeback is harmless
    for (int unsigned r = 0; r < 32; r++) begin
      bus.i_wb_valid = 1'b1;
      bus.i_wb_rd    = 5'(r);
      cyc();
    end
    bus.i_wb_valid = 1'b0;
    mid();
    check_eq("wb_drain_busy", 64'(bus.o_busy), 64'd0);
    cyc();

    // Fill x1..x31, then x0 operands must not stall
    for (int unsigned r = 1; r < 32; r++)
      run_simple(5'(r), 32'($urandom), 32'($urandom));
    mid();
    check_eq("fill_busy", 64'(bus.o_busy), 64'hFFFF_FFFE);
    cyc();
    bus.i_issue_ready = 1'b1;
    accept(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0200);
    mid();
    check_eq("x0_n1_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc(); mid();
    check_eq("x0_n2_valid", 64'(bus.o_issue_valid), 64'd1);
    cyc(); mid();
    check_eq("x0_busy", 64'(bus.o_busy), 64'hFFFF_FFFE);
    check_eq("x0_stall", 64'(bus.o_stall_count), 64'd5);
    cyc();

    // WAW on x9 with a disabled rs1 pointing at a busy register
    accept(5'd4, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0000_0909, 32'h0000_0204);
    mid();
    check_eq("waw_n1_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc(); mid();
    check_eq("waw_n2_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = 5'd9;
    mid();
    check_eq("waw_n3_valid", 64'(bus.o_issue_valid), 64'd0);
    cyc();
    bus.i_wb_valid = 1'b0;
    mid();
    check_eq("waw_issue_valid", 64'(bus.o_issue_valid), 64'd1);
    check_eq("waw_stall", 64'(bus.o_stall_count), 64'd7);
    cyc(); mid();
    check_eq("waw_busy", 64'(bus.o_busy), 64'hFFFF_FFFE);
    cyc();

    // Flush in ISSUE together with issue_ready
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = 5'd12;
    cyc();
    bus.i_wb_valid    = 1'b0;
    bus.i_issue_ready = 1'b0;
    accept(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 32'h0000_0C0C, 32'h0000_0300);
    cyc();
    bus.i_flush       = 1'b1;
    bus.i_issue_ready = 1'b1;
    void'(exp_q.pop_front());
    mid();
    check_eq("flush_valid_gated", 64'(bus.o_issue_valid), 64'd0);
    cyc();
    bus.i_flush       = 1'b0;
    bus.i_issue_ready = 1'b0;
    mid();
    check_eq("flush_busy", 64'(bus.o_busy), 64'hFFFF_EFFE);
    check_eq("flush_ready", 64'(bus.o_dec_ready), 64'd1);
    cyc();

    // Flush in IDLE drops the decoder instruction
    bus.i_dec_valid  = 1'b1;
    bus.i_dec_rd     = 5'd12;
    bus.i_dec_rd_en  = 1'b1;
    bus.i_flush      = 1'b1;
    cyc();
    bus.i_dec_valid  = 1'b0;
    bus.i_flush      = 1'b0;
    mid();
    check_eq("idle_flush_ready", 64'(bus.o_dec_ready), 64'd1);
    cyc(); mid();
    check_eq("idle_flush_valid", 64'(bus.o_issue_valid), 64'd0);
    check_eq("idle_flush_ready2", 64'(bus.o_dec_ready), 64'd1);
    cyc();

    // Reset while stalled in HAZARD
    accept(5'd1, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 32'h0000_0D0D, 32'h0000_0400);
    cyc(); mid();
    check_eq("pre_reset_stall", 64'(bus.o_stall_count), 64'd8);
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    exp_q.delete();
    mid();
    check_eq("hz_rst_busy",  64'(bus.o_busy), 64'd0);
    check_eq("hz_rst_stall", 64'(bus.o_stall_count), 64'd0);
    check_eq("hz_rst_ready", 64'(bus.o_dec_ready), 64'd1);
    check_eq("hz_rst_valid", 64'(bus.o_issue_valid), 64'd0);
    check_eq("hz_rst_rd",    64'(bus.o_issue_rd), 64'd0);
    cyc();

    // A few back-to-back instructions with random payloads after reset
    for (int unsigned r = 20; r < 24; r++)
      run_simple(5'(r), 32'($urandom), 32'($urandom));
    mid();
    check_eq("post_rst_busy", 64'(bus.o_busy), 64'h00F0_0000);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width carried through to o_issue_imm/o_issue_pc.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 i_clk  input  1  single clock; all state updates on posedge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_dec_valid  input  1  decoder holds a decoded instruction.
REQ-006 o_dec_ready  output  1  scoreboard accepts decoder instruction; drives decoder i_pipeline_ready.
REQ-007 i_dec_rs1, i_dec_rs2, i_dec_rd  input  5 each  register indices.
REQ-008 i_dec_rs1_en, i_dec_rs2_en, i_dec_rd_en  input  1 each  operand/destination used.
REQ-009 i_dec_imm, i_dec_pc  input  XLEN each  immediate and PC.
REQ-010 o_issue_valid  output  1  held instruction offered to execute.
REQ-011 i_issue_ready  input  1  execute accepts offered instruction.
REQ-012 o_issue_rs1, o_issue_rs2, o_issue_rd  output  5 each; o_issue_imm, o_issue_pc  output  XLEN each; registered copies.
REQ-013 i_wb_valid  input  1; i_wb_rd  input  5  writeback retiring a destination.
REQ-014 i_flush  input  1  discard held instruction (branch redirect).
REQ-015 o_busy  output  32  pending-write bit per register.
REQ-016 o_stall_count  output  CNT_W  cycles stalled on hazard, saturating.

Function
REQ-017 States: IDLE, HAZARD, ISSUE; encoded as enum.
REQ-018 IDLE: o_dec_ready=1; i_dec_valid=1 captures all i_dec_* fields (disabled index fields captured as 0) and goes to HAZARD next cycle.
REQ-019 HAZARD/ISSUE: o_dec_ready=0.
REQ-020 Hazard = (rs1_en & rs1!=0 & eff_busy[rs1]) | (rs2_en & rs2!=0 & eff_busy[rs2]) | (rd_en & rd!=0 & eff_busy[rd]) (RAW+WAW).
REQ-021 eff_busy = o_busy with bit i_wb_rd cleared when i_wb_valid=1 (same-cycle writeback bypass).
REQ-022 HAZARD: no hazard -> ISSUE next cycle; hazard -> stay, o_stall_count increments, saturating at all-ones.
REQ-023 ISSUE: o_issue_valid=1, outputs stable; i_issue_ready=1 -> IDLE next cycle, busy[rd] set if rd_en & rd!=0.
REQ-024 Minimum latency: accept cycle N, issue handshake earliest cycle N+2, next accept earliest N+3.
REQ-025 Writeback: i_wb_valid clears busy[i_wb_rd] next cycle in any state; i_wb_rd=0 no effect.
REQ-026 Same-cycle issue set and writeback clear on same index: set wins (bit ends 1).
REQ-027 busy[0] constantly 0.
REQ-028 i_flush=1 (not reset): next state IDLE, held instruction dropped, busy not set even if i_issue_ready=1 same cycle; o_issue_valid=0 in that cycle; writebacks still processed; o_busy otherwise kept.
REQ-029 i_flush in IDLE with i_dec_valid: instruction not captured.
REQ-030 o_issue_valid=0 outside ISSUE.

Reset
REQ-031 i_reset=1 at posedge: state IDLE, o_busy=0, o_stall_count=0, o_issue_* fields=0, o_issue_valid=0; priority over flush, writeback, handshakes.
REQ-032 Reset mid-HAZARD/ISSUE abandons held instruction without setting busy.
REQ-033 o_dec_ready=1 first cycle after reset deasserts.

Verification
REQ-034 No hazard: accept rd=5,rs1=1,rs2=2, i_issue_ready=1 -> o_issue_valid at N+2, o_busy=0x0000_0020 at N+3.
REQ-035 RAW: busy[5]=1, accept rs1=5 -> HAZARD; 4 cycles later i_wb_valid rd=5 -> issue next cycle, o_stall_count=4.
REQ-036 Bypass: in HAZARD waiting on rs2=7, i_wb_valid rd=7 same cycle -> ISSUE next cycle, busy[7]=0.
REQ-037 Set-wins: ISSUE rd=3 handshake with i_wb_valid rd=3 same cycle -> busy[3]=1 after.
REQ-038 x0: rd=0, rs1=0 with o_busy all ones except bit0 -> no stall, busy unchanged.
REQ-039 Flush/reset: i_flush with i_issue_ready in ISSUE -> IDLE, busy unchanged; reset in HAZARD -> o_busy=0, o_stall_count=0, o_dec_ready=1 next cycle.
